// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the writeback port arbiter: register file geometry,
// load funct3 encodings and the ALU skid-FIFO entry layout.
package wb_port_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Small ALU writeback skid FIFO. Pointers wrap naturally because DEPTH is a
// power of two; the entry storage itself is never reset.
module wb_skid_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        din,
  output wb_entry_t        dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Status flags and guarded push/pop; head entry is always visible.
  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    dout    = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: merges load returns and buffered ALU results onto one
// register-file write port, with a pending-load scoreboard for decode hazards.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  input  logic [2:0]            ld_funct3,
  input  logic                  ld_issue,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [2:0]            rf_funct3,
  output logic                  err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             rdy_en;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  wb_entry_t        fifo_head;
  wb_entry_t        fifo_din;
  logic             fifo_push;
  logic             fifo_pop;
  logic             ld_grant;
  logic             win_any;
  logic [REG_ADDR_W-1:0] win_rd;
  logic [XLEN-1:0]  win_data;
  logic [2:0]       win_f3;
  logic [31:0]      busy;
  logic [31:0]      set_vec;
  logic [31:0]      clr_vec;
  logic             err_issue;
  logic             err_grant;

  wb_skid_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Readies stay low through reset and rise on the first edge after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  // Arbitration: a load wins whenever it can be accepted, otherwise the FIFO head.
  always_comb begin
    alu_ready = rdy_en & ~fifo_full;
    ld_ready  = rdy_en & ~fifo_full;
    fifo_push = alu_valid & alu_ready;
    fifo_din  = '{rd: alu_rd, data: alu_data};
    ld_grant  = ld_valid & ld_ready;
    fifo_pop  = rdy_en & ~ld_grant & ~fifo_empty;
    win_any   = ld_grant | fifo_pop;
    win_rd    = ld_grant ? ld_rd     : fifo_head.rd;
    win_data  = ld_grant ? ld_data   : fifo_head.data;
    win_f3    = ld_grant ? ld_funct3 : F3_LW;
  end

  // Register the winner onto the register-file write port; x0 writes are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      rf_funct3 <= '0;
    end else begin
      rf_we <= win_any & (win_rd != '0);
      if (win_any) begin
        rf_waddr  <= win_rd;
        rf_wdata  <= win_data;
        rf_funct3 <= win_f3;
      end
    end
  end

  // Scoreboard set/clear vectors and protocol-error conditions.
  always_comb begin
    set_vec   = '0;
    clr_vec   = '0;
    if (ld_issue && ld_issue_rd != '0) set_vec = 32'd1 << ld_issue_rd;
    if (ld_grant && ld_rd != '0)       clr_vec = 32'd1 << ld_rd;
    err_issue = ld_issue & (ld_issue_rd != '0) & busy[ld_issue_rd] & ~clr_vec[ld_issue_rd];
    err_grant = ld_grant & (ld_rd != '0) & ~busy[ld_rd];
  end

  // Pending-load scoreboard (set beats clear) and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= (busy & ~clr_vec) | set_vec;
      err  <= err | err_issue | err_grant;
    end
  end

  // Decode hazard query, including a load return that is waiting this cycle.
  always_comb begin
    rs1_busy = (rs1 != '0) & (busy[rs1] | (ld_valid & (ld_rd == rs1) & ~ld_grant));
    rs2_busy = (rs2 != '0) & (busy[rs2] | (ld_valid & (ld_rd == rs2) & ~ld_grant));
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst) fifo_count <= CNT_W'(DEPTH));

endmodule
